// File: rtl/conv_window_gen_pkg.sv
// Shared definitions for the CNN window generator and the convolution engine:
// window FSM states, window width helpers and the (ch, ky, kx) -> sample index
// mapping. Both sides must pack data2conv with the same function.
package conv_window_gen_pkg;

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Number of samples carried by one window.
    function automatic int win_samples(input int cl_in, input int kernel);
        return cl_in * kernel * kernel;
    endfunction

    // Sample slot of channel ch, window row ky (0 = oldest), column kx (0 = leftmost).
    function automatic int win_idx(input int ch, input int ky, input int kx, input int kernel);
        return ch * kernel * kernel + ky * kernel + kx;
    endfunction

    // Counter width able to hold 0..depth-1 (never narrower than one bit).
    function automatic int cnt_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/conv_window_gen_line_buf.sv
// Single-row pixel delay: dout_o is the pixel accepted DEPTH beats ago.
// Advances only on accepted beats, so input gaps stall the delay line.
module line_buf
    import conv_window_gen_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din_i,
    input  logic             adv_i,
    output logic [WIDTH-1:0] dout_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Shift the row delay by one pixel on every accepted beat
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (adv_i) begin
            mem_q[0] <= din_i;
            for (int i = 1; i < DEPTH; i++) begin
                mem_q[i] <= mem_q[i-1];
            end
        end
    end

    assign dout_o = mem_q[DEPTH-1];

endmodule

// File: rtl/conv_window_gen.sv
// Streaming KERNEL x KERNEL window generator (stride 1, valid windows only).
// A chain of KERNEL-1 row delays supplies the vertical taps; a register array
// shifting left per accepted beat supplies the horizontal taps. The window is
// published on data2conv with a one-cycle en_out, one cycle after the pixel
// that completes it.
module conv_window_gen
    import conv_window_gen_pkg::*;
#(
    parameter int CL_IN  = 4,
    parameter int KERNEL = 3,
    parameter int N      = 2,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [CL_IN*N-1:0]                pix_in,
    input  logic                              pix_valid,
    output logic [CL_IN*KERNEL*KERNEL*N-1:0]  data2conv,
    output logic                              en_out,
    output logic                              frame_done
);

    localparam int PW = CL_IN * N;
    localparam int DW = win_samples(CL_IN, KERNEL) * N;
    localparam int CW = cnt_width(IMG_W);
    localparam int RW = cnt_width(IMG_H);

    localparam logic [CW-1:0] COL_LAST       = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST       = RW'(IMG_H - 1);
    localparam logic [RW-1:0] ROW_PRIME_LAST = RW'((KERNEL > 1) ? (KERNEL - 2) : 0);
    // A 1x1 kernel needs no priming rows, so it lives in ST_RUN permanently.
    localparam state_e        ST_INIT        = (KERNEL == 1) ? ST_RUN : ST_FILL;

    // chain_s[0] is the incoming pixel, chain_s[j] the same column j rows above.
    logic [PW-1:0] chain_s [KERNEL];

    logic [PW-1:0] win_q [KERNEL][KERNEL];
    logic [PW-1:0] win_d [KERNEL][KERNEL];

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    state_e        state_q, state_d;
    logic          en_q, en_d;
    logic          fd_q, fd_d;
    logic [DW-1:0] d2c_q, d2c_d;
    logic [DW-1:0] pack_s;
    logic          last_col_s;
    logic          last_row_s;
    logic          col_ok_s;

    assign chain_s[0] = pix_in;

    genvar g;
    for (g = 0; g < KERNEL - 1; g++) begin : g_lb
        line_buf #(
            .DEPTH (IMG_W),
            .WIDTH (PW)
        ) u_line_buf (
            .clk    (clk),
            .rst    (rst),
            .din_i  (chain_s[g]),
            .adv_i  (pix_valid),
            .dout_o (chain_s[g+1])
        );
    end

    // Next window: shift every row left and append the newest column on the right
    always_comb begin
        win_d = win_q;
        if (pix_valid) begin
            for (int ky = 0; ky < KERNEL; ky++) begin
                for (int kx = 0; kx < KERNEL - 1; kx++) begin
                    win_d[ky][kx] = win_q[ky][kx+1];
                end
                win_d[ky][KERNEL-1] = chain_s[KERNEL-1-ky];
            end
        end else begin
            win_d = win_q;
        end
    end

    // Pack the next window into the CE sample order
    always_comb begin
        pack_s = '0;
        for (int ch = 0; ch < CL_IN; ch++) begin
            for (int ky = 0; ky < KERNEL; ky++) begin
                for (int kx = 0; kx < KERNEL; kx++) begin
                    pack_s[win_idx(ch, ky, kx, KERNEL)*N +: N] = win_d[ky][kx][ch*N +: N];
                end
            end
        end
    end

    // Position counters, FSM next state and output next values
    always_comb begin
        col_d      = col_q;
        row_d      = row_q;
        state_d    = state_q;
        en_d       = 1'b0;
        fd_d       = 1'b0;
        d2c_d      = d2c_q;
        last_col_s = (col_q == COL_LAST);
        last_row_s = (row_q == ROW_LAST);
        col_ok_s   = (int'(col_q) >= KERNEL - 1);

        if (pix_valid) begin
            if (last_col_s) begin
                col_d = '0;
                if (last_row_s) begin
                    row_d = '0;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end else begin
                col_d = col_q + 1'b1;
            end
        end else begin
            col_d = col_q;
        end

        case (state_q)
            ST_FILL: begin
                if (pix_valid && last_col_s && (row_q == ROW_PRIME_LAST)) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_FILL;
                end
            end
            ST_RUN: begin
                if (pix_valid && last_col_s && last_row_s && (KERNEL > 1)) begin
                    state_d = ST_FILL;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase

        if (pix_valid && (state_q == ST_RUN) && col_ok_s) begin
            en_d  = 1'b1;
            fd_d  = last_col_s && last_row_s;
            d2c_d = pack_s;
        end else begin
            en_d  = 1'b0;
            fd_d  = 1'b0;
        end
    end

    // Register FSM state, counters and all outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_INIT;
            col_q   <= '0;
            row_q   <= '0;
            en_q    <= 1'b0;
            fd_q    <= 1'b0;
            d2c_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            en_q    <= en_d;
            fd_q    <= fd_d;
            d2c_q   <= d2c_d;
        end
    end

    // Hold the sliding window registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int ky = 0; ky < KERNEL; ky++) begin
                for (int kx = 0; kx < KERNEL; kx++) begin
                    win_q[ky][kx] <= '0;
                end
            end
        end else begin
            win_q <= win_d;
        end
    end

    assign data2conv  = d2c_q;
    assign en_out     = en_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// Bench for conv_window_gen: a 3x3 / 4x4-image instance and a 1x1 / 2-channel
// instance share clock, reset and pix_valid. A frame-image model derives each
// expected window from pixel positions.
module tb_conv_window_gen;

    localparam int N = 4;
    localparam int K = 3;
    localparam int W = 4;
    localparam int H = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  pix_in;
    logic        pix_valid;
    logic [35:0] d2c;
    logic        en;
    logic        fd;
    logic [3:0]  pix1;
    logic [3:0]  d2c1;
    logic        en1;
    logic        fd1;

    int          checks = 0;
    int          failures = 0;
    int          pos = 0;
    int          win_cnt = 0;
    logic [3:0]  img [H][W];
    logic [35:0] exp_d = '0;
    logic [3:0]  exp_d1 = '0;
    logic [35:0] first_win = '0;

    always #5 clk = ~clk;

    conv_window_gen #(.CL_IN(1), .KERNEL(3), .N(4), .IMG_W(4), .IMG_H(4)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .pix_in     (pix_in),
        .pix_valid  (pix_valid),
        .data2conv  (d2c),
        .en_out     (en),
        .frame_done (fd)
    );

    conv_window_gen #(.CL_IN(2), .KERNEL(1), .N(2), .IMG_W(4), .IMG_H(4)) u_dut1 (
        .clk        (clk),
        .rst        (rst),
        .pix_in     (pix1),
        .pix_valid  (pix_valid),
        .data2conv  (d2c1),
        .en_out     (en1),
        .frame_done (fd1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock: drive inputs, let the edge happen, compare against the model.
    task automatic beat(input logic v, input logic [3:0] p, input logic [3:0] q);
        bit emit;
        bit done;
        int r;
        int c;
        pix_valid = v;
        pix_in    = p;
        pix1      = q;
        @(posedge clk);
        #1;
        emit = 1'b0;
        done = 1'b0;
        if (v) begin
            r = pos / W;
            c = pos % W;
            img[r][c] = p;
            if (r >= K - 1 && c >= K - 1) begin
                emit = 1'b1;
                for (int ky = 0; ky < K; ky++) begin
                    for (int kx = 0; kx < K; kx++) begin
                        exp_d[(ky*K + kx)*N +: N] = img[r-K+1+ky][c-K+1+kx];
                    end
                end
            end
            done   = (pos == W*H - 1);
            exp_d1 = q;
            pos    = (pos + 1) % (W*H);
        end
        chk("en_out", 64'(en), 64'(emit));
        chk("frame_done", 64'(fd), 64'(emit && done));
        chk("data2conv", 64'(d2c), 64'(exp_d));
        chk("en_out_k1", 64'(en1), 64'(v));
        chk("frame_done_k1", 64'(fd1), 64'(v && done));
        chk("data2conv_k1", 64'(d2c1), 64'(exp_d1));
        if (en === 1'b1) begin
            if (win_cnt == 0) first_win = d2c;
            win_cnt++;
        end
    endtask

    // Assert reset away from the clock edge; outputs must drop at once.
    task automatic do_reset();
        pix_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("rst_en_async", 64'(en), 64'd0);
        chk("rst_fd_async", 64'(fd), 64'd0);
        chk("rst_en1_async", 64'(en1), 64'd0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            chk("rst_en_hold", 64'(en), 64'd0);
        end
        chk("rst_d2c", 64'(d2c), 64'd0);
        chk("rst_d2c1", 64'(d2c1), 64'd0);
        rst    = 1'b1;
        pos    = 0;
        exp_d  = '0;
        exp_d1 = '0;
    endtask

    initial begin
        logic [3:0] pv;
        rst = 1'b0;
        pix_valid = 1'b0;
        pix_in = 4'd0;
        pix1 = 4'd0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset_en", 64'(en), 64'd0);
        chk("reset_fd", 64'(fd), 64'd0);
        chk("reset_d2c", 64'(d2c), 64'd0);
        chk("reset_en1", 64'(en1), 64'd0);
        chk("reset_d2c1", 64'(d2c1), 64'd0);
        rst = 1'b1;

        // Single frame, continuous beats
        win_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            pv = 4'(i);
            beat(1'b1, pv, pv);
        end
        chk("s1_windows", 64'(win_cnt), 64'd4);
        chk("s1_first_win", 64'(first_win), 64'hA_9865_4210);
        beat(1'b0, 4'd0, 4'd0);

        // Alternating pix_valid
        win_cnt = 0;
        for (int i = 0; i < 32; i++) begin
            pv = (i % 2 == 0) ? 4'(i / 2) : 4'($urandom_range(0, 15));
            beat((i % 2 == 0), pv, pv);
        end
        chk("s2_windows", 64'(win_cnt), 64'd4);
        chk("s2_first_win", 64'(first_win), 64'hA_9865_4210);

        // Reset after pixel 9, then a full frame
        for (int i = 0; i < 10; i++) begin
            pv = 4'(i);
            beat(1'b1, pv, pv);
        end
        do_reset();
        win_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            pv = 4'(i);
            beat(1'b1, pv, pv);
            if (i < 10) chk("s3_no_early_win", 64'(win_cnt), 64'd0);
        end
        chk("s3_windows", 64'(win_cnt), 64'd4);
        chk("s3_first_win", 64'(first_win), 64'hA_9865_4210);

        // Two frames back-to-back
        win_cnt = 0;
        for (int i = 0; i < 32; i++) begin
            pv = 4'(i % 16);
            beat(1'b1, pv, pv);
        end
        chk("s4_windows", 64'(win_cnt), 64'd8);

        // Reset while a window is being presented
        for (int i = 0; i < 11; i++) begin
            pv = 4'(i);
            beat(1'b1, pv, pv);
        end
        do_reset();

        // Random pixels, random gaps, occasional reset
        win_cnt = 0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                beat(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            end
        end
        chk("s6_some_windows", 64'(win_cnt > 0), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
